// File: rtl/mul_share_arbiter.sv
`timescale 1ns/1ps
// mul_share_arbiter
// Shares the 2-stage integer multiplier between the core MUL issue path and
// the BiSoNN requester. BiSoNN ops are granted only on cycles the core leaves
// free, unless the pending op has lost STARVE_MAX cycles in a row to the core.
// Issued ops are shadowed for the two cycles they spend inside the
// multiplier so that a flush can send them back for replay. Results land in
// a response FIFO whose space is reserved at issue time, because the
// multiplier cannot be back-pressured.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   core_mul_req_i               core presents a MUL this cycle
//   core_mul_stall_o             core must hold its MUL this cycle
//   flush_i                      pipeline kill (also flushes the multiplier)
//   bis_req_*                    BiSoNN request (valid/ready, rs1, rs2, tag)
//   mul_bis_valid_o/rs1_o/rs2_o  BiSoNN side-band into the multiplier
//   mul_bis_valid_i/rd_i         BiSoNN result from the multiplier
//   bis_rsp_*                    BiSoNN response (valid/ready, data, tag)
module mul_share_arbiter #(
  parameter int TAG_W      = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_mul_req_i,
  output logic             core_mul_stall_o,
  input  logic             flush_i,
  input  logic             bis_req_valid_i,
  output logic             bis_req_ready_o,
  input  logic [63:0]      bis_req_rs1_i,
  input  logic [63:0]      bis_req_rs2_i,
  input  logic [TAG_W-1:0] bis_req_tag_i,
  output logic             mul_bis_valid_o,
  output logic [63:0]      mul_bis_rs1_o,
  output logic [63:0]      mul_bis_rs2_o,
  input  logic             mul_bis_valid_i,
  input  logic [63:0]      mul_bis_rd_i,
  output logic             bis_rsp_valid_o,
  input  logic             bis_rsp_ready_i,
  output logic [63:0]      bis_rsp_data_o,
  output logic [TAG_W-1:0] bis_rsp_tag_o
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [63:0]      rs1;
    logic [63:0]      rs2;
    logic [TAG_W-1:0] tag;
  } op_t;

  // shadow of the multiplier pipe: s0 = issued last cycle, s1 = returning now
  logic          s0_v, s1_v;
  op_t           s0, s1;

  // replay buffer, rp0 is the oldest entry
  op_t           rp0, rp1, rp0_n, rp1_n;
  logic [1:0]    rp_cnt, rp_cnt_n;

  logic [SW-1:0] starve;

  logic [63:0]      fifo_data [RSP_DEPTH];
  logic [TAG_W-1:0] fifo_tag  [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_cnt;

  op_t  new_op, src;
  logic use_replay, pending, may_issue, starved, grant, lose_to_core;
  logic push, pop;

  assign new_op     = '{rs1: bis_req_rs1_i, rs2: bis_req_rs2_i, tag: bis_req_tag_i};
  assign use_replay = (rp_cnt != 2'd0);
  assign pending    = use_replay | bis_req_valid_i;
  assign src        = use_replay ? rp0 : new_op;

  // space for everything already in the multiplier plus the new op
  assign may_issue = (32'(fifo_cnt) + 32'(s0_v) + 32'(s1_v) + 32'd1) <= 32'(RSP_DEPTH);
  assign starved   = (starve == SW'(STARVE_MAX));

  // rst_i gating keeps every output at 0 while reset is held, even with a
  // request sitting on the input
  assign grant = !rst_i && pending && may_issue && !flush_i &&
                 (!core_mul_req_i || starved);

  // only losing to the core ages a request; credit and flush stalls do not
  assign lose_to_core = pending && may_issue && !flush_i && core_mul_req_i && !starved;

  assign mul_bis_valid_o  = grant;
  assign mul_bis_rs1_o    = grant ? src.rs1 : 64'd0;
  assign mul_bis_rs2_o    = grant ? src.rs2 : 64'd0;
  assign core_mul_stall_o = grant && core_mul_req_i;
  assign bis_req_ready_o  = grant && !use_replay;

  // a result returning in the flush cycle is as dead as the ones behind it
  assign push = mul_bis_valid_i && s1_v && !flush_i;
  assign pop  = bis_rsp_valid_o && bis_rsp_ready_i;

  assign bis_rsp_valid_o = (fifo_cnt != '0);
  assign bis_rsp_data_o  = bis_rsp_valid_o ? fifo_data[rd_ptr] : 64'd0;
  assign bis_rsp_tag_o   = bis_rsp_valid_o ? fifo_tag[rd_ptr]  : '0;

  // Flushed shadow ops go in front of whatever is still waiting to replay:
  // s1 was issued before s0, and both were issued before any remaining entry.
  // At most two ops are ever outstanding between shadow and replay buffer
  // while the buffer is non-empty, so two entries suffice.
  always_comb begin
    rp0_n    = rp0;
    rp1_n    = rp1;
    rp_cnt_n = rp_cnt;
    if (flush_i) begin
      unique case ({s1_v, s0_v})
        2'b11: begin
          rp0_n    = s1;
          rp1_n    = s0;
          rp_cnt_n = rp_cnt + 2'd2;
        end
        2'b10: begin
          rp0_n    = s1;
          rp1_n    = rp0;
          rp_cnt_n = rp_cnt + 2'd1;
        end
        2'b01: begin
          rp0_n    = s0;
          rp1_n    = rp0;
          rp_cnt_n = rp_cnt + 2'd1;
        end
        default: ;
      endcase
    end else if (grant && use_replay) begin
      rp0_n    = rp1;
      rp_cnt_n = rp_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_v     <= 1'b0;
      s1_v     <= 1'b0;
      s0       <= '0;
      s1       <= '0;
      rp0      <= '0;
      rp1      <= '0;
      rp_cnt   <= 2'd0;
      starve   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      // killed ops drop out of the shadow, which also releases their credit
      s0_v   <= grant;
      s0     <= src;
      s1_v   <= s0_v && !flush_i;
      s1     <= s0;
      rp0    <= rp0_n;
      rp1    <= rp1_n;
      rp_cnt <= rp_cnt_n;

      if (grant)
        starve <= '0;
      else if (lose_to_core)
        starve <= starve + SW'(1);

      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= mul_bis_rd_i;
      fifo_tag[wr_ptr]  <= s1.tag;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && fifo_cnt == CW'(RSP_DEPTH)));

  a_replay_fits: assert property (@(posedge clk_i) disable iff (rst_i)
    !(flush_i && (32'(rp_cnt) + 32'(s0_v) + 32'(s1_v)) > 32'd2));

endmodule

// File: tb/tb_mul_share_arbiter.sv
`timescale 1ns/1ps
// Testbench for mul_share_arbiter: directed scenarios followed by random
// traffic. A behavioural multiplier returns rs1*rs2 two cycles after issue
// and corrupts any op a flush hits, so a captured killed result shows up as
// bad data. A scoreboard expects every accepted request to come back exactly
// once, in acceptance order, with the right product and tag.
module tb_mul_share_arbiter;

  localparam int TAG_W      = 4;
  localparam int RSP_DEPTH  = 4;
  localparam int STARVE_MAX = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             core_mul_req_i = 1'b0;
  logic             core_mul_stall_o;
  logic             flush_i = 1'b0;
  logic             bis_req_valid_i = 1'b0;
  logic             bis_req_ready_o;
  logic [63:0]      bis_req_rs1_i = '0;
  logic [63:0]      bis_req_rs2_i = '0;
  logic [TAG_W-1:0] bis_req_tag_i = '0;
  logic             mul_bis_valid_o;
  logic [63:0]      mul_bis_rs1_o;
  logic [63:0]      mul_bis_rs2_o;
  logic             mul_bis_valid_i;
  logic [63:0]      mul_bis_rd_i;
  logic             bis_rsp_valid_o;
  logic             bis_rsp_ready_i = 1'b0;
  logic [63:0]      bis_rsp_data_o;
  logic [TAG_W-1:0] bis_rsp_tag_o;

  mul_share_arbiter #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_mul_req_i(core_mul_req_i), .core_mul_stall_o(core_mul_stall_o),
    .flush_i(flush_i),
    .bis_req_valid_i(bis_req_valid_i), .bis_req_ready_o(bis_req_ready_o),
    .bis_req_rs1_i(bis_req_rs1_i), .bis_req_rs2_i(bis_req_rs2_i), .bis_req_tag_i(bis_req_tag_i),
    .mul_bis_valid_o(mul_bis_valid_o), .mul_bis_rs1_o(mul_bis_rs1_o), .mul_bis_rs2_o(mul_bis_rs2_o),
    .mul_bis_valid_i(mul_bis_valid_i), .mul_bis_rd_i(mul_bis_rd_i),
    .bis_rsp_valid_o(bis_rsp_valid_o), .bis_rsp_ready_i(bis_rsp_ready_i),
    .bis_rsp_data_o(bis_rsp_data_o), .bis_rsp_tag_o(bis_rsp_tag_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // behavioural 2-cycle multiplier; a flush anywhere on an op's way through
  // corrupts its result
  logic        m0_v = 1'b0, m1_v = 1'b0, m0_bad = 1'b0, m1_bad = 1'b0;
  logic [63:0] m0_a = '0, m0_b = '0, m1_a = '0, m1_b = '0;
  logic [63:0] m_prod;

  always @(posedge clk_i) begin
    m0_v   <= mul_bis_valid_o;
    m0_a   <= mul_bis_rs1_o;
    m0_b   <= mul_bis_rs2_o;
    m0_bad <= flush_i;
    m1_v   <= m0_v;
    m1_a   <= m0_a;
    m1_b   <= m0_b;
    m1_bad <= m0_bad | flush_i;
  end

  assign m_prod          = m1_a * m1_b;
  assign mul_bis_valid_i = m1_v;
  assign mul_bis_rd_i    = (m1_bad | flush_i) ? ~m_prod : m_prod;

  // scoreboard
  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (bis_req_valid_i && bis_req_ready_o) begin
        exp_e.data = bis_req_rs1_i * bis_req_rs2_i;
        exp_e.tag  = bis_req_tag_i;
        exp_q.push_back(exp_e);
      end
      check("credit_bound", 64'(exp_q.size() <= RSP_DEPTH), 64'd1);
      check("single_issuer", 64'(core_mul_req_i && !core_mul_stall_o && mul_bis_valid_o), 64'd0);
      check("no_issue_on_flush", 64'(flush_i && mul_bis_valid_o), 64'd0);
      if (bis_rsp_valid_o && bis_rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(bis_rsp_valid_o), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_data", bis_rsp_data_o, exp_e.data);
          check("rsp_tag", 64'(bis_rsp_tag_o), 64'(exp_e.tag));
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int  acc;
  int  idx;
  bit  held;

  initial begin
    // reset state, with a request already presented
    bis_req_valid_i = 1'b1;
    core_mul_req_i  = 1'b1;
    @(negedge clk_i);
    check("rst_mul_valid", 64'(mul_bis_valid_o), 64'd0);
    check("rst_req_ready", 64'(bis_req_ready_o), 64'd0);
    check("rst_stall", 64'(core_mul_stall_o), 64'd0);
    check("rst_rsp_valid", 64'(bis_rsp_valid_o), 64'd0);
    check("rst_rsp_data", bis_rsp_data_o, 64'd0);
    bis_req_valid_i = 1'b0;
    core_mul_req_i  = 1'b0;
    step();
    rst_i = 1'b0;
    idle(2);

    // idle core: same-cycle grant, response three cycles after acceptance
    bis_rsp_ready_i = 1'b1;
    bis_req_valid_i = 1'b1;
    bis_req_rs1_i   = 64'd7;
    bis_req_rs2_i   = 64'd6;
    bis_req_tag_i   = 4'd3;
    @(negedge clk_i);
    check("idle_grant", 64'(mul_bis_valid_o), 64'd1);
    check("idle_ready", 64'(bis_req_ready_o), 64'd1);
    check("idle_rs1", mul_bis_rs1_o, 64'd7);
    check("idle_rs2", mul_bis_rs2_o, 64'd6);
    step();
    bis_req_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      check("idle_rsp_valid", 64'(bis_rsp_valid_o), 64'(c == 3));
      if (c == 3) begin
        check("idle_rsp_data", bis_rsp_data_o, 64'd42);
        check("idle_rsp_tag", 64'(bis_rsp_tag_o), 64'd3);
      end
      step();
    end
    idle(2);

    // busy core: forced through on cycle STARVE_MAX+1
    core_mul_req_i  = 1'b1;
    bis_req_valid_i = 1'b1;
    bis_req_rs1_i   = 64'd11;
    bis_req_rs2_i   = 64'd13;
    bis_req_tag_i   = 4'd5;
    for (int c = 1; c <= STARVE_MAX + 1; c++) begin
      @(negedge clk_i);
      check("starve_grant", 64'(mul_bis_valid_o), 64'(c == STARVE_MAX + 1));
      check("starve_stall", 64'(core_mul_stall_o), 64'(c == STARVE_MAX + 1));
      step();
    end
    core_mul_req_i  = 1'b0;
    bis_req_valid_i = 1'b0;
    idle(5);

    // response backpressure: only RSP_DEPTH requests fit
    bis_rsp_ready_i = 1'b0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      bis_req_valid_i = (idx < 6);
      bis_req_rs1_i   = 64'(idx + 100);
      bis_req_rs2_i   = 64'(idx + 3);
      bis_req_tag_i   = TAG_W'(idx + 8);
      @(negedge clk_i);
      if (bis_req_valid_i && bis_req_ready_o) begin
        acc++;
        idx++;
      end
      if (c == 9) check("bp_ready_low", 64'(bis_req_ready_o), 64'd0);
      step();
    end
    check("bp_accepted", 64'(acc), 64'(RSP_DEPTH));
    bis_req_valid_i = 1'b0;
    bis_rsp_ready_i = 1'b1;
    idle(12);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // flush kills two in-flight ops, which replay in order
    bis_req_rs1_i   = 64'hFFFF_FFFF_FFFF_FFFF;
    bis_req_rs2_i   = 64'd2;
    bis_req_valid_i = 1'b1;
    bis_req_tag_i   = 4'd1;
    @(negedge clk_i);
    check("fl_grant1", 64'(mul_bis_valid_o), 64'd1);
    step();
    bis_req_tag_i = 4'd2;
    @(negedge clk_i);
    check("fl_grant2", 64'(mul_bis_valid_o), 64'd1);
    step();
    bis_req_valid_i = 1'b0;
    flush_i         = 1'b1;
    @(negedge clk_i);
    check("fl_no_grant", 64'(mul_bis_valid_o), 64'd0);
    step();
    flush_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check("fl_replay", 64'(mul_bis_valid_o), 64'd1);
      check("fl_replay_rs1", mul_bis_rs1_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check("fl_replay_rs2", mul_bis_rs2_o, 64'd2);
      step();
    end
    @(negedge clk_i);
    check("fl_no_extra", 64'(mul_bis_valid_o), 64'd0);
    idle(6);
    check("fl_drained", 64'(exp_q.size()), 64'd0);

    // flush with a request pending and nothing in flight
    bis_req_valid_i = 1'b1;
    bis_req_rs1_i   = 64'd9;
    bis_req_rs2_i   = 64'd10;
    bis_req_tag_i   = 4'd9;
    flush_i         = 1'b1;
    @(negedge clk_i);
    check("fp_no_grant", 64'(mul_bis_valid_o), 64'd0);
    check("fp_no_ready", 64'(bis_req_ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("fp_grant_next", 64'(mul_bis_valid_o), 64'd1);
    step();
    bis_req_valid_i = 1'b0;
    idle(5);

    // a flush cycle does not age a request losing to the core
    core_mul_req_i  = 1'b1;
    bis_req_valid_i = 1'b1;
    bis_req_tag_i   = 4'd10;
    for (int c = 1; c <= STARVE_MAX + 2; c++) begin
      flush_i = (c == 4);
      @(negedge clk_i);
      check("fs_grant", 64'(mul_bis_valid_o), 64'(c == STARVE_MAX + 2));
      step();
    end
    flush_i         = 1'b0;
    core_mul_req_i  = 1'b0;
    bis_req_valid_i = 1'b0;
    idle(6);

    // reset mid-operation
    bis_rsp_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bis_req_valid_i = 1'b1;
      bis_req_rs1_i   = 64'(c + 20);
      bis_req_rs2_i   = 64'd3;
      bis_req_tag_i   = TAG_W'(c);
      step();
    end
    bis_req_valid_i = 1'b0;
    step();
    bis_req_valid_i = 1'b1;
    core_mul_req_i  = 1'b1;
    rst_i           = 1'b1;
    #1;
    check("mrst_rsp_valid", 64'(bis_rsp_valid_o), 64'd0);
    check("mrst_rsp_data", bis_rsp_data_o, 64'd0);
    check("mrst_mul_valid", 64'(mul_bis_valid_o), 64'd0);
    check("mrst_ready", 64'(bis_req_ready_o), 64'd0);
    check("mrst_stall", 64'(core_mul_stall_o), 64'd0);
    idle(2);
    rst_i           = 1'b0;
    bis_req_valid_i = 1'b0;
    core_mul_req_i  = 1'b0;
    bis_rsp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check("mrst_no_rsp", 64'(bis_rsp_valid_o), 64'd0);
      step();
    end
    bis_req_valid_i = 1'b1;
    bis_req_rs1_i   = 64'd9;
    bis_req_rs2_i   = 64'd9;
    bis_req_tag_i   = 4'd4;
    @(negedge clk_i);
    check("mrst_new_grant", 64'(mul_bis_valid_o), 64'd1);
    step();
    bis_req_valid_i = 1'b0;
    idle(2);
    @(negedge clk_i);
    check("mrst_new_rsp", 64'(bis_rsp_valid_o), 64'd1);
    check("mrst_new_data", bis_rsp_data_o, 64'd81);
    step();
    idle(2);

    // random traffic; a request is held until accepted
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      core_mul_req_i  = 1'($urandom_range(0, 1));
      flush_i         = ($urandom_range(0, 19) == 0);
      bis_rsp_ready_i = ($urandom_range(0, 9) < 7);
      if (!held) begin
        bis_req_valid_i = ($urandom_range(0, 9) < 6);
        bis_req_rs1_i   = {$urandom, $urandom};
        bis_req_rs2_i   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
        bis_req_tag_i   = TAG_W'($urandom_range(0, 15));
      end
      @(negedge clk_i);
      held = bis_req_valid_i && !bis_req_ready_o;
      step();
    end
    core_mul_req_i  = 1'b0;
    flush_i         = 1'b0;
    bis_req_valid_i = 1'b0;
    bis_rsp_ready_i = 1'b1;
    idle(30);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
